fwrisc_exec_arith_scoreboard: RTL and testbench

Parametrised scoreboard for the exec unit's ALU instructions, usable both in simulation and in formal.
- Queues up to DEPTH arithmetic instructions captured at decode.
- Tracks register-file writes against the oldest queued instruction.
- On instr_complete, checks the write count, destination and result value against an XLEN-wide reference model.
- Reports a sticky first-error code plus saturating error and instruction counters.

---
 rtl/fwrisc_exec_arith_scoreboard_if.sv | 42 ++++
 rtl/fwrisc_exec_arith_scoreboard.sv | 218 +++++++++++++++++++++
 tb/tb_fwrisc_exec_arith_scoreboard.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fwrisc_exec_arith_scoreboard_if.sv
// fwrisc_exec_arith_scoreboard_if
// Bundles the decode, register-write and retire strobes with the scoreboard
// status outputs. The "master" modport is the stimulus side (core or bench).
// The "slave" modport is the scoreboard itself.
interface fwrisc_exec_arith_scoreboard_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic              decode_valid;
    logic [4:0]        op_type;
    logic [5:0]        op;
    logic [XLEN-1:0]   op_a;
    logic [XLEN-1:0]   op_b;
    logic [5:0]        rd;
    logic              rd_wen;
    logic [5:0]        rd_waddr;
    logic [XLEN-1:0]   rd_wdata;
    logic              instr_complete;

    logic              err;
    logic [2:0]        err_code;
    logic [CNT_W-1:0]  err_count;
    logic [CNT_W-1:0]  instr_count;
    logic [PW-1:0]     pending;
    logic              full;
    logic [10:0]       op_seen;

    modport master (
        output decode_valid, op_type, op, op_a, op_b, rd,
               rd_wen, rd_waddr, rd_wdata, instr_complete,
        input  err, err_code, err_count, instr_count, pending, full, op_seen
    );

    modport slave (
        input  decode_valid, op_type, op, op_a, op_b, rd,
               rd_wen, rd_waddr, rd_wdata, instr_complete,
        output err, err_code, err_count, instr_count, pending, full, op_seen
    );
endinterface

// File: rtl/fwrisc_exec_arith_scoreboard.sv
// fwrisc_exec_arith_scoreboard
// Queues decoded ALU instructions and checks each retirement. At retirement it
// checks the register-file write count, the destination and the result value
// against a reference ALU. It reports a sticky first-error code and saturating
// error and instruction counters.
// Optional per-op coverage: define FWRISC_ARITH_SB_COVER_EN.
// Op encodings: ADD=0, SUB=1, AND=2, OR=3, CLR=4, EQ=5, LT=6, LTU=7, XOR=8,
// OPA=9, OPB=10. The ARITH op_type encoding is given by OP_TYPE_ARITH.
module fwrisc_exec_arith_scoreboard #(
    parameter int         XLEN          = 32,
    parameter int         DEPTH         = 4,
    parameter int         CNT_W         = 8,
    parameter logic [4:0] OP_TYPE_ARITH = 5'd0
) (
    input logic                           clock,
    input logic                           reset,
    fwrisc_exec_arith_scoreboard_if.slave sb
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    localparam logic [5:0] OP_ADD = 6'd0,  OP_SUB = 6'd1, OP_AND = 6'd2,
                           OP_OR  = 6'd3,  OP_CLR = 6'd4, OP_EQ  = 6'd5,
                           OP_LT  = 6'd6,  OP_LTU = 6'd7, OP_XOR = 6'd8,
                           OP_OPA = 6'd9,  OP_OPB = 6'd10;

    typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_WAIT_WR = 2'd1, ST_WR_SEEN = 2'd2} state_e;

    typedef struct packed {
        logic            illegal;
        logic [5:0]      op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [5:0]      rd;
    } entry_t;

    // Reference ALU result for a legal arithmetic op
    function automatic logic [XLEN-1:0] alu_ref(input logic [5:0] op,
                                                input logic [XLEN-1:0] a,
                                                input logic [XLEN-1:0] b);
        case (op)
            OP_ADD:  alu_ref = a + b;
            OP_SUB:  alu_ref = a - b;
            OP_AND:  alu_ref = a & b;
            OP_OR:   alu_ref = a | b;
            OP_CLR:  alu_ref = b ^ (a & b);
            OP_EQ:   alu_ref = {{(XLEN-1){1'b0}}, (a == b)};
            OP_LT:   alu_ref = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_LTU:  alu_ref = {{(XLEN-1){1'b0}}, (a < b)};
            OP_XOR:  alu_ref = a ^ b;
            OP_OPA:  alu_ref = a;
            OP_OPB:  alu_ref = b;
            default: alu_ref = {XLEN{1'b0}};
        endcase
    endfunction

    // True when the decoded instruction is an ARITH op the model knows
    function automatic logic is_legal(input logic [4:0] op_type, input logic [5:0] op);
        is_legal = (op_type == OP_TYPE_ARITH) && (op <= OP_OPB);
    endfunction

    entry_t           mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    count_q, count_d;
    state_e           state_q, state_d;
    logic [1:0]       wr_count_q, wr_count_d;
    logic [5:0]       waddr_q, waddr_d;
    logic [XLEN-1:0]  wdata_q, wdata_d;
    logic             err_q, err_d;
    logic [2:0]       err_code_q, err_code_d;
    logic [CNT_W-1:0] err_count_q, err_count_d, instr_count_q, instr_count_d;
    logic [10:0]      op_seen_q, op_seen_d;

    logic             empty_s, full_s, bypass_s, underflow_s, overflow_s;
    logic             pop_s, push_s, retire_s, fail_s;
    entry_t           in_s, head_s;
    logic [1:0]       wc_s;
    logic [5:0]       waddr_s;
    logic [XLEN-1:0]  wdata_s;
    logic [2:0]       chk_code_s;

    // Classify this cycle's events and evaluate the retirement check
    always_comb begin
        empty_s     = (count_q == {PW{1'b0}});
        full_s      = (count_q == PW'(DEPTH));
        bypass_s    = sb.instr_complete && empty_s && sb.decode_valid;
        underflow_s = sb.instr_complete && empty_s && !sb.decode_valid;
        pop_s       = sb.instr_complete && !empty_s;
        overflow_s  = sb.decode_valid && full_s && !sb.instr_complete;
        push_s      = sb.decode_valid && !bypass_s && !overflow_s;
        retire_s    = pop_s || bypass_s;
        in_s        = '{illegal: !is_legal(sb.op_type, sb.op), op: sb.op,
                        a: sb.op_a, b: sb.op_b, rd: sb.rd};
        head_s      = bypass_s ? in_s : mem_q[rd_ptr_q];
        // A same-cycle write belongs to the retiring instruction
        wc_s        = (sb.rd_wen && (wr_count_q != 2'd3)) ? (wr_count_q + 2'd1) : wr_count_q;
        waddr_s     = sb.rd_wen ? sb.rd_waddr : waddr_q;
        wdata_s     = sb.rd_wen ? sb.rd_wdata : wdata_q;
        chk_code_s  = 3'd0;
        if (underflow_s) begin
            chk_code_s = 3'd7;
        end else if (retire_s) begin
            if (head_s.illegal)                                    chk_code_s = 3'd5;
            else if (wc_s == 2'd0)                                 chk_code_s = 3'd1;
            else if (wc_s > 2'd1)                                  chk_code_s = 3'd2;
            else if (waddr_s != head_s.rd)                         chk_code_s = 3'd3;
            else if (wdata_s != alu_ref(head_s.op, head_s.a, head_s.b)) chk_code_s = 3'd4;
            else                                                   chk_code_s = 3'd0;
        end else if (overflow_s) begin
            chk_code_s = 3'd6;
        end else begin
            chk_code_s = 3'd0;
        end
        fail_s = (chk_code_s != 3'd0);
    end

    // Next-state for FIFO pointers, head state machine and status counters
    always_comb begin
        wr_ptr_d      = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
        rd_ptr_d      = pop_s ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
        count_d       = count_q + PW'(push_s) - PW'(pop_s);
        state_d       = state_q;
        wr_count_d    = wr_count_q;
        waddr_d       = waddr_q;
        wdata_d       = wdata_q;
        if (retire_s) begin
            state_d    = (count_d != {PW{1'b0}}) ? ST_WAIT_WR : ST_EMPTY;
            wr_count_d = 2'd0;
            waddr_d    = 6'd0;
            wdata_d    = {XLEN{1'b0}};
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push_s) state_d = ST_WAIT_WR;
                    else        state_d = ST_EMPTY;
                end
                ST_WAIT_WR, ST_WR_SEEN: begin
                    if (sb.rd_wen) begin
                        state_d    = ST_WR_SEEN;
                        wr_count_d = wc_s;
                        waddr_d    = sb.rd_waddr;
                        wdata_d    = sb.rd_wdata;
                    end else begin
                        state_d    = state_q;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
        err_d         = err_q || fail_s;
        err_code_d    = (fail_s && !err_q) ? chk_code_s : err_code_q;
        err_count_d   = (fail_s && (err_count_q != {CNT_W{1'b1}})) ? (err_count_q + CNT_W'(1)) : err_count_q;
        instr_count_d = (retire_s && (instr_count_q != {CNT_W{1'b1}})) ? (instr_count_q + CNT_W'(1)) : instr_count_q;
`ifdef FWRISC_ARITH_SB_COVER_EN
        op_seen_d     = (retire_s && !fail_s) ? (op_seen_q | (11'd1 << head_s.op)) : op_seen_q;
`else
        op_seen_d     = 11'd0;
`endif
    end

    // State and status registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= {AW{1'b0}};
            rd_ptr_q      <= {AW{1'b0}};
            count_q       <= {PW{1'b0}};
            state_q       <= ST_EMPTY;
            wr_count_q    <= 2'd0;
            waddr_q       <= 6'd0;
            wdata_q       <= {XLEN{1'b0}};
            err_q         <= 1'b0;
            err_code_q    <= 3'd0;
            err_count_q   <= {CNT_W{1'b0}};
            instr_count_q <= {CNT_W{1'b0}};
            op_seen_q     <= 11'd0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            state_q       <= state_d;
            wr_count_q    <= wr_count_d;
            waddr_q       <= waddr_d;
            wdata_q       <= wdata_d;
            err_q         <= err_d;
            err_code_q    <= err_code_d;
            err_count_q   <= err_count_d;
            instr_count_q <= instr_count_d;
            op_seen_q     <= op_seen_d;
        end
    end

    // Instruction storage; the tail slot is written on every stored push
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (push_s) begin
            mem_q[wr_ptr_q] <= in_s;
        end else begin
            mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
        end
    end

`ifdef FWRISC_ARITH_SB_COVER_EN
    for (genvar g = 0; g < 11; g++) begin : g_op_cover
        cover property (@(posedge clock) disable iff (reset)
                        retire_s && !fail_s && (head_s.op == 6'(g)));
    end
    cover property (@(posedge clock) disable iff (reset) instr_count_q == CNT_W'(DEPTH));
`endif

    assign sb.err         = err_q;
    assign sb.err_code    = err_code_q;
    assign sb.err_count   = err_count_q;
    assign sb.instr_count = instr_count_q;
    assign sb.pending     = count_q;
    assign sb.full        = (count_q == PW'(DEPTH));
    assign sb.op_seen     = op_seen_q;
endmodule

// File: tb/tb_fwrisc_exec_arith_scoreboard.sv
// Directed, table-driven bench for fwrisc_exec_arith_scoreboard (XLEN=32, DEPTH=4).
module tb_fwrisc_exec_arith_scoreboard;
    localparam logic [4:0] ARITH  = 5'd0;
    localparam logic [4:0] NOARTH = 5'd3;
    localparam logic [5:0] ADD = 6'd0, SUB = 6'd1, AND_ = 6'd2, OR_ = 6'd3, CLR = 6'd4,
                           EQ = 6'd5, LT = 6'd6, LTU = 6'd7, XOR_ = 6'd8, OPA = 6'd9, OPB = 6'd10;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp  = 0;
    int   n_fail = 0;

    fwrisc_exec_arith_scoreboard_if #(.XLEN(32), .DEPTH(4), .CNT_W(8)) sb_if ();

    fwrisc_exec_arith_scoreboard #(.XLEN(32), .DEPTH(4), .CNT_W(8)) dut (
        .clock (clock),
        .reset (reset),
        .sb    (sb_if)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [5:0]  rd;
        logic [31:0] res;
    } vec_t;
    vec_t vecs [12];

    task automatic clear_in();
        sb_if.decode_valid   = 1'b0;
        sb_if.op_type        = 5'd0;
        sb_if.op             = 6'd0;
        sb_if.op_a           = 32'd0;
        sb_if.op_b           = 32'd0;
        sb_if.rd             = 6'd0;
        sb_if.rd_wen         = 1'b0;
        sb_if.rd_waddr       = 6'd0;
        sb_if.rd_wdata       = 32'd0;
        sb_if.instr_complete = 1'b0;
    endtask

    task automatic push(input logic [4:0] ot, input logic [5:0] op,
                        input logic [31:0] a, input logic [31:0] b, input logic [5:0] rd);
        sb_if.decode_valid = 1'b1;
        sb_if.op_type      = ot;
        sb_if.op           = op;
        sb_if.op_a         = a;
        sb_if.op_b         = b;
        sb_if.rd           = rd;
    endtask

    task automatic wr(input logic [5:0] addr, input logic [31:0] data);
        sb_if.rd_wen   = 1'b1;
        sb_if.rd_waddr = addr;
        sb_if.rd_wdata = data;
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        clear_in();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    initial begin
        vecs[0]  = '{ADD,  32'hFFFFFFFF, 32'h00000001, 6'd5,  32'h00000000};
        vecs[1]  = '{SUB,  32'h00000005, 32'h00000007, 6'd2,  32'hFFFFFFFE};
        vecs[2]  = '{AND_, 32'hF0F0F0F0, 32'h3C3C3C3C, 6'd6,  32'h30303030};
        vecs[3]  = '{OR_,  32'hF0F0F0F0, 32'h0F0F0000, 6'd7,  32'hFFFFF0F0};
        vecs[4]  = '{CLR,  32'hFF00FF00, 32'h0F0F0F0F, 6'd8,  32'h000F000F};
        vecs[5]  = '{EQ,   32'h00001234, 32'h00001234, 6'd9,  32'h00000001};
        vecs[6]  = '{EQ,   32'h00001234, 32'h00001235, 6'd10, 32'h00000000};
        vecs[7]  = '{LT,   32'h80000000, 32'h00000001, 6'd3,  32'h00000001};
        vecs[8]  = '{LTU,  32'h80000000, 32'h00000001, 6'd3,  32'h00000000};
        vecs[9]  = '{XOR_, 32'hAAAA5555, 32'hFFFF0000, 6'd11, 32'h55555555};
        vecs[10] = '{OPA,  32'hDEADBEEF, 32'h12345678, 6'd12, 32'hDEADBEEF};
        vecs[11] = '{OPB,  32'h11111111, 32'hCAFEF00D, 6'd13, 32'hCAFEF00D};

        clear_in();
        repeat (2) @(posedge clock);
        #1;
        // Reset state
        check("rst_err",         32'(sb_if.err),         32'd0);
        check("rst_err_code",    32'(sb_if.err_code),    32'd0);
        check("rst_pending",     32'(sb_if.pending),     32'd0);
        check("rst_full",        32'(sb_if.full),        32'd0);
        check("rst_instr_count", 32'(sb_if.instr_count), 32'd0);
        check("rst_err_count",   32'(sb_if.err_count),   32'd0);
        check("rst_op_seen",     32'(sb_if.op_seen),     32'd0);
        reset = 1'b0;

        // Table: push, write, complete for each passing vector
        for (int i = 0; i < 12; i++) begin
            push(ARITH, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd);
            tick();
            check("vec_pending1", 32'(sb_if.pending), 32'd1);
            wr(vecs[i].rd, vecs[i].res);
            tick();
            sb_if.instr_complete = 1'b1;
            tick();
            check("vec_err",         32'(sb_if.err),         32'd0);
            check("vec_err_code",    32'(sb_if.err_code),    32'd0);
            check("vec_instr_count", 32'(sb_if.instr_count), 32'(i + 1));
            check("vec_pending0",    32'(sb_if.pending),     32'd0);
        end
        check("tbl_err_count", 32'(sb_if.err_count), 32'd0);
`ifdef FWRISC_ARITH_SB_COVER_EN
        check("tbl_op_seen", 32'(sb_if.op_seen), 32'h000007FF);
`else
        check("tbl_op_seen", 32'(sb_if.op_seen), 32'h00000000);
`endif

        // Fill to DEPTH, overflow, then drain
        do_reset();
        for (int k = 0; k < 4; k++) begin
            push(ARITH, ADD, 32'(k), 32'd10, 6'(k + 1));
            tick();
        end
        check("fill_pending", 32'(sb_if.pending), 32'd4);
        check("fill_full",    32'(sb_if.full),    32'd1);
        check("fill_err",     32'(sb_if.err),     32'd0);
        push(ARITH, ADD, 32'd100, 32'd1, 6'd9);
        tick();
        check("ovf_err",       32'(sb_if.err),       32'd1);
        check("ovf_err_code",  32'(sb_if.err_code),  32'd6);
        check("ovf_err_count", 32'(sb_if.err_count), 32'd1);
        check("ovf_pending",   32'(sb_if.pending),   32'd4);
        for (int k = 0; k < 4; k++) begin
            wr(6'(k + 1), 32'(k + 10));
            if (k % 2 == 1) tick();
            sb_if.instr_complete = 1'b1;
            tick();
        end
        check("drain_pending",     32'(sb_if.pending),     32'd0);
        check("drain_full",        32'(sb_if.full),        32'd0);
        check("drain_instr_count", 32'(sb_if.instr_count), 32'd4);
        check("drain_err_count",   32'(sb_if.err_count),   32'd1);
        check("drain_err_code",    32'(sb_if.err_code),    32'd6);

        // Multiple writes, then later failures keep the first code
        do_reset();
        push(ARITH, SUB, 32'd5, 32'd7, 6'd2);
        tick();
        wr(6'd2, 32'hFFFFFFFE);
        tick();
        wr(6'd2, 32'hFFFFFFFE);
        tick();
        sb_if.instr_complete = 1'b1;
        tick();
        check("mw_err",         32'(sb_if.err),         32'd1);
        check("mw_err_code",    32'(sb_if.err_code),    32'd2);
        check("mw_err_count",   32'(sb_if.err_count),   32'd1);
        check("mw_instr_count", 32'(sb_if.instr_count), 32'd1);
        push(ARITH, ADD, 32'd1, 32'd1, 6'd4);
        tick();
        wr(6'd4, 32'd3);
        tick();
        sb_if.instr_complete = 1'b1;
        tick();
        check("dm_err_code",  32'(sb_if.err_code),  32'd2);
        check("dm_err_count", 32'(sb_if.err_count), 32'd2);
        push(NOARTH, ADD, 32'd1, 32'd1, 6'd4);
        tick();
        wr(6'd4, 32'd2);
        tick();
        sb_if.instr_complete = 1'b1;
        tick();
        check("ill_err_count", 32'(sb_if.err_count), 32'd3);
        push(ARITH, ADD, 32'd2, 32'd2, 6'd8);
        tick();
        wr(6'd9, 32'd4);
        tick();
        sb_if.instr_complete = 1'b1;
        tick();
        check("rdm_err_count", 32'(sb_if.err_count), 32'd4);
        push(ARITH, OPA, 32'd7, 32'd0, 6'd1);
        tick();
        sb_if.instr_complete = 1'b1;
        tick();
        check("nw_err_count",   32'(sb_if.err_count),   32'd5);
        check("nw_instr_count", 32'(sb_if.instr_count), 32'd5);
        check("nw_err_code",    32'(sb_if.err_code),    32'd2);

        // Bypass on empty, then push+complete while full
        do_reset();
        push(ARITH, OR_, 32'h0000000F, 32'h000000F0, 6'd7);
        wr(6'd7, 32'h000000FF);
        sb_if.instr_complete = 1'b1;
        tick();
        check("byp_err",         32'(sb_if.err),         32'd0);
        check("byp_instr_count", 32'(sb_if.instr_count), 32'd1);
        check("byp_pending",     32'(sb_if.pending),     32'd0);
        for (int k = 1; k <= 4; k++) begin
            push(ARITH, OPB, 32'd0, 32'(k), 6'(k + 1));
            tick();
        end
        check("fpc_full_before", 32'(sb_if.full), 32'd1);
        push(ARITH, OPB, 32'd0, 32'd5, 6'd6);
        wr(6'd2, 32'd1);
        sb_if.instr_complete = 1'b1;
        tick();
        check("fpc_pending",     32'(sb_if.pending),     32'd4);
        check("fpc_err",         32'(sb_if.err),         32'd0);
        check("fpc_instr_count", 32'(sb_if.instr_count), 32'd2);
        for (int k = 2; k <= 5; k++) begin
            wr(6'(k + 1), 32'(k));
            sb_if.instr_complete = 1'b1;
            tick();
        end
        check("fpc_drain_pending", 32'(sb_if.pending),     32'd0);
        check("fpc_drain_icount",  32'(sb_if.instr_count), 32'd6);
        check("fpc_drain_err",     32'(sb_if.err),         32'd0);

        // Reset with entries pending, then underflow and counter saturation
        do_reset();
        for (int k = 0; k < 3; k++) begin
            push(ARITH, ADD, 32'd1, 32'd2, 6'd3);
            tick();
        end
        check("rmid_pending_before", 32'(sb_if.pending), 32'd3);
        reset = 1'b1;
        #1;
        check("rmid_pending", 32'(sb_if.pending), 32'd0);
        check("rmid_err",     32'(sb_if.err),     32'd0);
        @(negedge clock);
        reset = 1'b0;
        sb_if.instr_complete = 1'b1;
        tick();
        check("uf_err",         32'(sb_if.err),         32'd1);
        check("uf_err_code",    32'(sb_if.err_code),    32'd7);
        check("uf_err_count",   32'(sb_if.err_count),   32'd1);
        check("uf_instr_count", 32'(sb_if.instr_count), 32'd0);
        for (int k = 0; k < 260; k++) begin
            sb_if.instr_complete = 1'b1;
            tick();
        end
        check("sat_err_count",   32'(sb_if.err_count),   32'd255);
        check("sat_instr_count", 32'(sb_if.instr_count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
